// File: rtl/pulseox_pkg.sv
// pulseox_pkg: shared phase/state types and sample width for the pulse-oximeter channel path
package pulseox_pkg;
  localparam int ADC_W = 8;
  typedef enum logic {PH_RED, PH_IR} phase_e;
  typedef enum logic [1:0] {IDLE, SETTLE, WAIT, HOLD} state_e;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: LED phase counter with phase toggle, wrap and settle-match flags
module phase_timer #(
  parameter int PHASE_CYCLES  = 25,
  parameter int SETTLE_CYCLES = 10
) (
  input  logic                CLK_Filter,
  input  logic                rst_n,
  input  logic                enable_i,
  output logic [7:0]          cnt_o,
  output pulseox_pkg::phase_e phase_o,
  output logic                wrap_o,
  output logic                settle_hit_o
);
  import pulseox_pkg::*;
  logic   run_q;
  logic   [7:0] cnt_q, cnt_d;
  phase_e ph_q, ph_d;
  assign cnt_o        = cnt_q;
  assign phase_o      = ph_q;
  assign wrap_o       = run_q && (cnt_q == 8'(PHASE_CYCLES - 1));
  assign settle_hit_o = run_q && (cnt_q == 8'(SETTLE_CYCLES - 1));
  // The first enabled cycle only leaves idle, so counting starts from 0 one cycle later
  always_comb begin
    cnt_d = (enable_i && run_q && !wrap_o) ? cnt_q + 8'd1 : '0;
    ph_d  = !enable_i ? PH_RED : wrap_o ? (ph_q == PH_RED ? PH_IR : PH_RED) : ph_q;
  end
  // Timer state register
  always_ff @(posedge CLK_Filter or negedge rst_n)
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      ph_q  <= PH_RED;
    end else begin
      run_q <= enable_i;
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
endmodule

// File: rtl/red_ir_sampler.sv
// red_ir_sampler: red/IR LED sequencer with ADC handshake and sample demux; RED_IR_SAMPLER_DEADTIME_EN adds LED blanking
module red_ir_sampler #(
  parameter int PHASE_CYCLES  = 25,
  parameter int SETTLE_CYCLES = 10,
  parameter int DEAD_CYCLES   = 2,
  parameter int ADC_W         = pulseox_pkg::ADC_W
) (
  input  logic             CLK_Filter,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_done,
  output logic             adc_start,
  output logic             LED_RED,
  output logic             LED_IR,
  output logic [ADC_W-1:0] RED_ADC_Value,
  output logic [ADC_W-1:0] IR_ADC_Value,
  output logic             red_valid,
  output logic             ir_valid,
  output logic             adc_timeout
);
  import pulseox_pkg::*;
  logic [7:0] cnt;
  phase_e     ph;
  logic       wrap, settle_hit, take, nxt_red, led_on;
  state_e     st_q, st_d;
  logic       start_q, start_d, led_red_q, led_red_d, led_ir_q, led_ir_d;
  logic       red_vld_q, red_vld_d, ir_vld_q, ir_vld_d, tmo_q, tmo_d;
  logic [ADC_W-1:0] red_q, red_d, ir_q, ir_d;

  phase_timer #(.PHASE_CYCLES(PHASE_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .CLK_Filter  (CLK_Filter),
    .rst_n       (rst_n),
    .enable_i    (enable),
    .cnt_o       (cnt),
    .phase_o     (ph),
    .wrap_o      (wrap),
    .settle_hit_o(settle_hit)
  );

`ifdef RED_IR_SAMPLER_DEADTIME_EN
  assign led_on = enable && ((((st_q == IDLE) || wrap) ? 8'd0 : cnt + 8'd1) >= 8'(DEAD_CYCLES));
`else
  logic unused_cfg;
  assign unused_cfg = ^{cnt, 8'(DEAD_CYCLES)};
  assign led_on = enable;
`endif

  // Next-state and registered outputs; a done on the wrap cycle wins over the timeout
  always_comb begin
    take      = (st_q == WAIT) && adc_done;
    nxt_red   = (st_q == IDLE) || (wrap ? ph == PH_IR : ph == PH_RED);
    st_d      = !enable ? IDLE : ((st_q == IDLE) || wrap) ? SETTLE : take ? HOLD :
                ((st_q == SETTLE) && settle_hit) ? WAIT : st_q;
    start_d   = enable && (st_q == SETTLE) && settle_hit;
    led_red_d = led_on && nxt_red;
    led_ir_d  = led_on && !nxt_red;
    red_vld_d = enable && take && (ph == PH_RED);
    ir_vld_d  = enable && take && (ph == PH_IR);
    red_d     = red_vld_d ? adc_data : red_q;
    ir_d      = ir_vld_d ? adc_data : ir_q;
    tmo_d     = enable && (tmo_q || ((st_q == WAIT) && wrap && !adc_done));
  end

  // State and output registers
  always_ff @(posedge CLK_Filter or negedge rst_n)
    if (!rst_n) begin
      st_q      <= IDLE;
      start_q   <= 1'b0;
      led_red_q <= 1'b0;
      led_ir_q  <= 1'b0;
      red_vld_q <= 1'b0;
      ir_vld_q  <= 1'b0;
      tmo_q     <= 1'b0;
      red_q     <= '0;
      ir_q      <= '0;
    end else begin
      st_q      <= st_d;
      start_q   <= start_d;
      led_red_q <= led_red_d;
      led_ir_q  <= led_ir_d;
      red_vld_q <= red_vld_d;
      ir_vld_q  <= ir_vld_d;
      tmo_q     <= tmo_d;
      red_q     <= red_d;
      ir_q      <= ir_d;
    end

  assign adc_start     = start_q;
  assign LED_RED       = led_red_q;
  assign LED_IR        = led_ir_q;
  assign RED_ADC_Value = red_q;
  assign IR_ADC_Value  = ir_q;
  assign red_valid     = red_vld_q;
  assign ir_valid      = ir_vld_q;
  assign adc_timeout   = tmo_q;
endmodule

// File: tb/tb_red_ir_sampler.sv
// tb_red_ir_sampler: directed stimulus, phase-arithmetic reference model and per-cycle compare
module tb_red_ir_sampler;
  localparam int P = 25, S = 10, DEAD = 2;
`ifdef RED_IR_SAMPLER_DEADTIME_EN
  localparam int DX = DEAD;
`else
  localparam int DX = 0;
`endif
  logic CLK_Filter = 1'b0, rst_n = 1'b1, enable = 1'b0, adc_done = 1'b0;
  logic [7:0] adc_data = 8'h00;
  logic adc_start, LED_RED, LED_IR, red_valid, ir_valid, adc_timeout;
  logic [7:0] RED_ADC_Value, IR_ADC_Value;
  int total = 0, bad = 0;
  bit m_act = 0, m_wait = 0, m_start = 0, m_lr = 0, m_li = 0, m_rv = 0, m_iv = 0, m_tmo = 0;
  int m_k = 0;
  logic [7:0] m_red = 8'h00, m_ir = 8'h00;
  bit silent = 0;
  int cd = 0;
  logic [7:0] cd_data = 8'h00, red_data = 8'h00, ir_data = 8'h00;

  red_ir_sampler #(.PHASE_CYCLES(P), .SETTLE_CYCLES(S), .DEAD_CYCLES(DEAD), .ADC_W(8)) dut (
    .CLK_Filter(CLK_Filter), .rst_n(rst_n), .enable(enable), .adc_data(adc_data), .adc_done(adc_done),
    .adc_start(adc_start), .LED_RED(LED_RED), .LED_IR(LED_IR), .RED_ADC_Value(RED_ADC_Value),
    .IR_ADC_Value(IR_ADC_Value), .red_valid(red_valid), .ir_valid(ir_valid), .adc_timeout(adc_timeout)
  );

  always #5 CLK_Filter = ~CLK_Filter;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: position in the sequence is k cycles since start; phase = (k/P)%2, counter = k%P
  always @(posedge CLK_Filter or negedge rst_n) begin : model
    int k, pos, npos;
    bit ph, nph, take;
    if (!rst_n) begin
      m_act <= 0; m_k <= 0; m_wait <= 0; m_start <= 0; m_lr <= 0; m_li <= 0;
      m_rv <= 0; m_iv <= 0; m_tmo <= 0; m_red <= 8'h00; m_ir <= 8'h00;
    end else if (!enable) begin
      m_act <= 0; m_k <= 0; m_wait <= 0; m_start <= 0; m_lr <= 0; m_li <= 0;
      m_rv <= 0; m_iv <= 0; m_tmo <= 0;
    end else begin
      k = m_act ? m_k + 1 : 0;
      pos = m_k % P;
      ph = bit'((m_k / P) % 2);
      npos = k % P;
      nph = bit'((k / P) % 2);
      take = m_act && m_wait && adc_done;
      m_rv <= take && !ph;
      m_iv <= take && ph;
      if (take && !ph) m_red <= adc_data;
      if (take && ph) m_ir <= adc_data;
      m_tmo <= m_tmo || (m_act && m_wait && !adc_done && pos == P - 1);
      m_wait <= (npos == S) || (m_wait && !take && pos != P - 1);
      m_start <= (npos == S);
      m_lr <= !nph && npos >= DX;
      m_li <= nph && npos >= DX;
      m_act <= 1;
      m_k <= k;
    end
  end

  always @(negedge CLK_Filter) begin
    chk("adc_start", 32'(adc_start), 32'(m_start));
    chk("LED_RED", 32'(LED_RED), 32'(m_lr));
    chk("LED_IR", 32'(LED_IR), 32'(m_li));
    chk("led_overlap", 32'(LED_RED & LED_IR), 32'd0);
    chk("red_valid", 32'(red_valid), 32'(m_rv));
    chk("ir_valid", 32'(ir_valid), 32'(m_iv));
    chk("RED_ADC_Value", 32'(RED_ADC_Value), 32'(m_red));
    chk("IR_ADC_Value", 32'(IR_ADC_Value), 32'(m_ir));
    chk("adc_timeout", 32'(adc_timeout), 32'(m_tmo));
  end

  // ADC stand-in: answers 3 cycles after adc_start unless silenced
  task automatic tick();
    @(negedge CLK_Filter);
    adc_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        adc_done = 1'b1;
        adc_data = cd_data;
      end
    end
    if (adc_start && !silent) begin
      cd = 3;
      cd_data = LED_RED ? red_data : ir_data;
    end
  endtask

  task automatic wait_pos(input bit ph, input int pos, output int n);
    n = 0;
    while (!(m_act && (m_k % P) == pos && bit'((m_k / P) % 2) == ph) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL wait_pos: phase %0d counter %0d not reached within %0d cycles", ph, pos, n);
    end
  endtask

  initial begin
    int n, n2, s_red, s_ir, s_st, s_rv, s_iv, dt, vt;
    s_red = 0; s_ir = 0; s_st = 0; s_rv = 0; s_iv = 0; dt = -1; vt = -1;
    red_data = 8'hA5;
    ir_data = 8'h3C;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_leds", 32'({LED_RED, LED_IR, adc_start}), 32'd0);
    chk("rst_values", 32'({RED_ADC_Value, IR_ADC_Value}), 32'd0);
    chk("rst_flags", 32'({red_valid, ir_valid, adc_timeout}), 32'd0);
    rst_n = 1'b1;
    tick();
    enable = 1'b1;
    for (int i = 1; i <= 2 * P; i++) begin
      tick();
      if (i <= P) s_red += int'(LED_RED);
      else s_ir += int'(LED_IR);
      s_st += int'(adc_start);
      s_iv += int'(ir_valid);
      if (red_valid) begin
        s_rv++;
        vt = i;
      end
      if (adc_done && i <= P) dt = i;
    end
    chk("t1_red_cycles", 32'(s_red), 32'(P - DX));
    chk("t1_ir_cycles", 32'(s_ir), 32'(P - DX));
    chk("t1_start_count", 32'(s_st), 32'd2);
    chk("t2_red_valid_count", 32'(s_rv), 32'd1);
    chk("t2_ir_valid_count", 32'(s_iv), 32'd1);
    chk("t2_valid_latency", 32'(vt), 32'(dt + 1));
    chk("t2_red_value", 32'(RED_ADC_Value), 32'hA5);
    chk("t2_ir_value", 32'(IR_ADC_Value), 32'h3C);
    wait_pos(1, 0, n);
    silent = 1;
    wait_pos(0, 0, n);
    silent = 0;
    chk("t3_timeout_set", 32'(adc_timeout), 32'd1);
    chk("t3_ir_held", 32'(IR_ADC_Value), 32'h3C);
    red_data = 8'h66;
    wait_pos(0, 15, n);
    chk("t3_red_sampled", 32'(RED_ADC_Value), 32'h66);
    chk("t3_timeout_sticky", 32'(adc_timeout), 32'd1);
    red_data = 8'h11;
    wait_pos(1, 0, n);
    wait_pos(0, 11, n);
    chk("t5_timeout_before", 32'(adc_timeout), 32'd1);
    enable = 1'b0;
    tick();
    chk("t5_leds_off", 32'({LED_RED, LED_IR}), 32'd0);
    chk("t5_timeout_clr", 32'(adc_timeout), 32'd0);
    tick();
    tick();
    tick();
    chk("t5_no_valid", 32'(red_valid), 32'd0);
    chk("t5_red_held", 32'(RED_ADC_Value), 32'h66);
    silent = 1;
    enable = 1'b1;
    wait_pos(0, 5, n);
    adc_done = 1'b1;
    adc_data = 8'h55;
    wait_pos(0, 10, n2);
    chk("t5_restart_latency", 32'(n + n2), 32'(S + 1));
    chk("t5_restart_start", 32'({adc_start, LED_RED}), 32'b11);
    wait_pos(0, 24, n);
    chk("t4_spurious_ignored", 32'({red_valid, RED_ADC_Value}), 32'h066);
    adc_done = 1'b1;
    adc_data = 8'h7F;
    tick();
    silent = 0;
    chk("t4_wrap_valid", 32'(red_valid), 32'd1);
    chk("t4_wrap_value", 32'(RED_ADC_Value), 32'h7F);
    chk("t4_no_timeout", 32'(adc_timeout), 32'd0);
    wait_pos(1, 15, n);
    chk("t6_ir_before", 32'({LED_IR, RED_ADC_Value}), 32'h17F);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_leds", 32'({LED_RED, LED_IR, adc_start}), 32'd0);
    chk("t6_async_values", 32'({RED_ADC_Value, IR_ADC_Value}), 32'd0);
    chk("t6_async_flags", 32'({red_valid, ir_valid, adc_timeout}), 32'd0);
    tick();
    rst_n = 1'b1;
    wait_pos(0, 1, n);
    chk("t6_red_cnt1", 32'(LED_RED), 32'(DX <= 1));
    wait_pos(0, 2, n);
    chk("t6_red_cnt2", 32'(LED_RED), 32'd1);
    wait_pos(1, 1, n);
    chk("t6_ir_cnt1", 32'({LED_RED, LED_IR}), 32'(DX <= 1));
    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
